// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// Digit order everywhere: d3..d0 = seconds tens, seconds ones, tenths, hundredths.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        LAP     = 2'd2,
        STOPPED = 2'd3
    } sw_state_t;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] MAX_D3 = 4'd5;
    localparam logic [DIGIT_W-1:0] MAX_D2 = 4'd9;
    localparam logic [DIGIT_W-1:0] MAX_D1 = 4'd9;
    localparam logic [DIGIT_W-1:0] MAX_D0 = 4'd9;

    // True when the live count sits at 59.99, the last value before wrap.
    function automatic logic is_max(input logic [DIGIT_W-1:0] d3,
                                    input logic [DIGIT_W-1:0] d2,
                                    input logic [DIGIT_W-1:0] d1,
                                    input logic [DIGIT_W-1:0] d0);
        return (d3 == MAX_D3) && (d2 == MAX_D2) && (d1 == MAX_D1) && (d0 == MAX_D0);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Bundle between the board/core side (master) and the stopwatch controller (slave).
// Buttons and live digits flow into the controller; run/clear/lap and display digits flow out.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic               btn_start_stop;
    logic               btn_lap_clear;
    logic [DIGIT_W-1:0] live_digit0;
    logic [DIGIT_W-1:0] live_digit1;
    logic [DIGIT_W-1:0] live_digit2;
    logic [DIGIT_W-1:0] live_digit3;
    logic               run;
    logic               sw_clear;
    logic               lap_active;
    logic [DIGIT_W-1:0] disp_digit0;
    logic [DIGIT_W-1:0] disp_digit1;
    logic [DIGIT_W-1:0] disp_digit2;
    logic [DIGIT_W-1:0] disp_digit3;

    modport master (
        output btn_start_stop, btn_lap_clear,
        output live_digit0, live_digit1, live_digit2, live_digit3,
        input  run, sw_clear, lap_active,
        input  disp_digit0, disp_digit1, disp_digit2, disp_digit3
    );

    modport slave (
        input  btn_start_stop, btn_lap_clear,
        input  live_digit0, live_digit1, live_digit2, live_digit3,
        output run, sw_clear, lap_active,
        output disp_digit0, disp_digit1, disp_digit2, disp_digit3
    );

endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// button_debounce: 2-FF synchronizer, stable-level debounce counter, one-cycle press pulse.
// Pulse is registered: high the cycle after the debounced level rises; releases produce nothing.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        // Any cycle where the synced input agrees with the level restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch button controller: debounced start/stop and lap/clear drive a run/lap/clear FSM and lap-freeze display.
// Optional STOPWATCH_AUTOSTOP_EN: stop automatically when the live count reaches 59.99.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               reset_n,
    stopwatch_ctrl_if.slave    bus
);

    logic ss_pulse;
    logic lc_pulse;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (bus.btn_start_stop),
        .press_pulse (ss_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap_clear (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_raw     (bus.btn_lap_clear),
        .press_pulse (lc_pulse)
    );

    sw_state_t          state_q, state_d;
    logic               run_q, run_d;
    logic               sw_clear_q, sw_clear_d;
    logic               lap_active_q, lap_active_d;
    logic [DIGIT_W-1:0] lap_q   [4];
    logic [DIGIT_W-1:0] lap_d   [4];
    logic [DIGIT_W-1:0] disp_q  [4];
    logic [DIGIT_W-1:0] disp_d  [4];
    logic [DIGIT_W-1:0] live    [4];

    assign live[0] = bus.live_digit0;
    assign live[1] = bus.live_digit1;
    assign live[2] = bus.live_digit2;
    assign live[3] = bus.live_digit3;

    always_comb begin
        state_d    = state_q;
        sw_clear_d = 1'b0;
        lap_d      = lap_q;
        // start_stop is tested first in every state so it wins a same-cycle collision.
        unique case (state_q)
            IDLE: begin
                if (ss_pulse) state_d = RUNNING;
            end
            RUNNING: begin
                if (ss_pulse) begin
                    state_d = STOPPED;
                end else if (lc_pulse) begin
                    state_d = LAP;
                    lap_d   = live;
                end
            end
            LAP: begin
                if (ss_pulse)      state_d = STOPPED;
                else if (lc_pulse) state_d = RUNNING;
            end
            STOPPED: begin
                if (ss_pulse) begin
                    state_d = RUNNING;
                end else if (lc_pulse) begin
                    state_d    = IDLE;
                    sw_clear_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef STOPWATCH_AUTOSTOP_EN
        if ((state_q == RUNNING || state_q == LAP) &&
            is_max(live[3], live[2], live[1], live[0])) begin
            state_d = STOPPED;
            lap_d   = lap_q;
        end
`endif
        run_d        = (state_d == RUNNING) || (state_d == LAP);
        lap_active_d = (state_d == LAP);
        // On the entry edge the lap regs are still loading, so show live (same value) that one time.
        if (state_d == LAP && state_q == LAP) disp_d = lap_q;
        else                                  disp_d = live;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            run_q        <= 1'b0;
            sw_clear_q   <= 1'b0;
            lap_active_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lap_q[i]  <= '0;
                disp_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            sw_clear_q   <= sw_clear_d;
            lap_active_q <= lap_active_d;
            for (int i = 0; i < 4; i++) begin
                lap_q[i]  <= lap_d[i];
                disp_q[i] <= disp_d[i];
            end
        end
    end

    assign bus.run         = run_q;
    assign bus.sw_clear    = sw_clear_q;
    assign bus.lap_active  = lap_active_q;
    assign bus.disp_digit0 = disp_q[0];
    assign bus.disp_digit1 = disp_q[1];
    assign bus.disp_digit2 = disp_q[2];
    assign bus.disp_digit3 = disp_q[3];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short debounce window; expected values are hand-derived.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sw_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_live(input logic [15:0] v);
        sw_if.live_digit3 = v[15:12];
        sw_if.live_digit2 = v[11:8];
        sw_if.live_digit1 = v[7:4];
        sw_if.live_digit0 = v[3:0];
    endtask

    function automatic logic [15:0] disp();
        return {sw_if.disp_digit3, sw_if.disp_digit2, sw_if.disp_digit1, sw_if.disp_digit0};
    endfunction

    // sel 0 = start_stop, 1 = lap_clear; press for 10 cycles, release for 10.
    task automatic press(input int sel);
        if (sel == 0) sw_if.btn_start_stop = 1'b1;
        else          sw_if.btn_lap_clear  = 1'b1;
        tick(10);
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_lap_clear  = 1'b0;
        tick(10);
    endtask

    initial begin
        int clr_seen;
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_lap_clear  = 1'b0;
        set_live(16'h0000);
        #1;
        check("reset_run", {15'd0, sw_if.run}, 16'd0);
        check("reset_disp", disp(), 16'h0000);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // 2-cycle glitch must not start the watch.
        sw_if.btn_start_stop = 1'b1;
        tick(2);
        sw_if.btn_start_stop = 1'b0;
        tick(10);
        check("glitch_no_run", {15'd0, sw_if.run}, 16'd0);

        // Start press: pulse after 6 edges, run one edge later.
        sw_if.btn_start_stop = 1'b1;
        tick(5);
        check("ss_pulse_early", {15'd0, dut.ss_pulse}, 16'd0);
        tick(1);
        check("ss_pulse_high", {15'd0, dut.ss_pulse}, 16'd1);
        check("run_before_edge", {15'd0, sw_if.run}, 16'd0);
        tick(1);
        check("ss_pulse_done", {15'd0, dut.ss_pulse}, 16'd0);
        check("run_after_start", {15'd0, sw_if.run}, 16'd1);
        tick(3);
        sw_if.btn_start_stop = 1'b0;
        tick(10);
        check("run_after_release", {15'd0, sw_if.run}, 16'd1);

        // Lap freeze.
        set_live(16'h0321);
        sw_if.btn_lap_clear = 1'b1;
        tick(7);
        check("lap_active_on", {15'd0, sw_if.lap_active}, 16'd1);
        check("lap_disp_capture", disp(), 16'h0321);
        set_live(16'h0456);
        tick(2);
        check("lap_disp_hold", disp(), 16'h0321);
        check("lap_run", {15'd0, sw_if.run}, 16'd1);
        sw_if.btn_lap_clear = 1'b0;
        tick(10);
        check("lap_disp_hold2", disp(), 16'h0321);
        sw_if.btn_lap_clear = 1'b1;
        tick(7);
        check("lap_active_off", {15'd0, sw_if.lap_active}, 16'd0);
        check("unfreeze_disp", disp(), 16'h0456);
        set_live(16'h0789);
        check("disp_latency", disp(), 16'h0456);
        tick(1);
        check("disp_tracks", disp(), 16'h0789);
        sw_if.btn_lap_clear = 1'b0;
        tick(10);

        // Stop then clear.
        press(0);
        check("stopped_run", {15'd0, sw_if.run}, 16'd0);
        sw_if.btn_lap_clear = 1'b1;
        tick(6);
        check("clr_before", {15'd0, sw_if.sw_clear}, 16'd0);
        tick(1);
        check("clr_pulse", {15'd0, sw_if.sw_clear}, 16'd1);
        check("clr_run", {15'd0, sw_if.run}, 16'd0);
        tick(1);
        check("clr_one_cycle", {15'd0, sw_if.sw_clear}, 16'd0);
        sw_if.btn_lap_clear = 1'b0;
        tick(10);
        clr_seen = 0;
        sw_if.btn_lap_clear = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (i == 10) sw_if.btn_lap_clear = 1'b0;
            if (sw_if.sw_clear) clr_seen++;
        end
        check("idle_no_clear", 16'(clr_seen), 16'd0);
        check("idle_no_run", {15'd0, sw_if.run}, 16'd0);

        // Simultaneous presses: start_stop wins.
        press(0);
        check("restart_run", {15'd0, sw_if.run}, 16'd1);
        sw_if.btn_start_stop = 1'b1;
        sw_if.btn_lap_clear  = 1'b1;
        tick(7);
        check("both_run", {15'd0, sw_if.run}, 16'd0);
        check("both_lap", {15'd0, sw_if.lap_active}, 16'd0);
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_lap_clear  = 1'b0;
        tick(10);
        clr_seen = 0;
        sw_if.btn_lap_clear = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (i == 10) sw_if.btn_lap_clear = 1'b0;
            if (sw_if.sw_clear) clr_seen++;
        end
        check("both_was_stopped", 16'(clr_seen), 16'd1);

        // Async reset in LAP.
        press(0);
        set_live(16'h0142);
        press(1);
        check("pre_reset_lap", {15'd0, sw_if.lap_active}, 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_run", {15'd0, sw_if.run}, 16'd0);
        check("arst_lap", {15'd0, sw_if.lap_active}, 16'd0);
        check("arst_clr", {15'd0, sw_if.sw_clear}, 16'd0);
        check("arst_disp", disp(), 16'h0000);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        press(0);
        check("post_reset_run", {15'd0, sw_if.run}, 16'd1);

        // Max count behaviour.
        set_live(16'h5999);
        tick(1);
`ifdef STOPWATCH_AUTOSTOP_EN
        check("autostop_run", {15'd0, sw_if.run}, 16'd0);
        set_live(16'h0000);
        tick(3);
        check("autostop_stays", {15'd0, sw_if.run}, 16'd0);
`else
        check("max_keeps_run", {15'd0, sw_if.run}, 16'd1);
        set_live(16'h0000);
        tick(3);
        check("wrap_keeps_run", {15'd0, sw_if.run}, 16'd1);
`endif
        check("max_disp", disp(), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
